// File: rtl/prover_tree_pkg.sv
// Shared field constants and tree-shape helpers for the prover adder tree.
package prover_tree_pkg;

  localparam int unsigned F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};  // 2^61 - 1

  typedef logic [F_NBITS-1:0] fe_t;

  function automatic int unsigned num_levels(input int unsigned ngates);
    return 32'($clog2(ngates));
  endfunction

  // Element count entering a given level; odd counts round up.
  function automatic int unsigned lvl_num_inputs(input int unsigned ngates,
                                                 input int unsigned level);
    int unsigned n;
    n = ngates;
    for (int unsigned k = 0; k < level; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Element offset of a level within the flattened inter-level data bus.
  function automatic int unsigned lvl_offset(input int unsigned ngates,
                                             input int unsigned level);
    int unsigned off;
    off = 0;
    for (int unsigned k = 0; k < level; k++) off += lvl_num_inputs(ngates, k);
    return off;
  endfunction

  function automatic fe_t mod_add(input fe_t a, input fe_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/prover_tree_stage_vr.sv
// One elastic level of the adder tree: pairwise mod-add of NIN elements,
// odd element passed through, registered with a valid/ready handshake.
module prover_tree_stage_vr
  import prover_tree_pkg::*;
#(
  parameter int unsigned NIN   = 2,
  parameter int unsigned NTAGB = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             up_valid,
  output logic                             up_ready_c,
  input  logic [NIN-1:0][F_NBITS-1:0]      up_data,
  input  logic [NTAGB-1:0]                 up_tag,
  output logic                             dn_valid,
  input  logic                             dn_ready,
  output logic [(NIN+1)/2-1:0][F_NBITS-1:0] dn_data,
  output logic [NTAGB-1:0]                 dn_tag
);

  localparam int unsigned NOUT = (NIN + 1) / 2;

  logic [NOUT-1:0][F_NBITS-1:0] sum_c;

  for (genvar j = 0; j < NOUT; j++) begin : g_pair
    if (2 * j + 1 < NIN) begin : g_add
      assign sum_c[j] = mod_add(up_data[2*j], up_data[2*j+1]);
    end else begin : g_pass
      assign sum_c[j] = up_data[2*j];
    end
  end

  assign up_ready_c = ~dn_valid | dn_ready;

  // Data and tag hold when no beat is loaded; only valid tracks bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_tag   <= '0;
    end else if (up_ready_c) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= sum_c;
        dn_tag  <= up_tag;
      end
    end
  end

endmodule

// File: rtl/prover_adder_tree_vr.sv
// Pipelined elastic field adder tree reducing NGATES masked elements mod F_Q.
// Optional accumulate-across-beats mode: PROVER_ADDER_TREE_ACC_EN.
module prover_adder_tree_vr
  import prover_tree_pkg::*;
#(
  parameter int unsigned NGATES = 8,
  parameter int unsigned NTAGB  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NGATES-1:0][F_NBITS-1:0] in,
  input  logic [NGATES-1:0]              in_mask,
  input  logic [NTAGB-1:0]               in_tag,
`ifdef PROVER_ADDER_TREE_ACC_EN
  input  logic                           in_last,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [F_NBITS-1:0]             out,
  output logic [NTAGB-1:0]               out_tag,
  output logic                           idle
);

  localparam int unsigned NLEVELS = num_levels(NGATES);
  localparam int unsigned NELEMS  = lvl_offset(NGATES, NLEVELS + 1);
`ifdef PROVER_ADDER_TREE_ACC_EN
  localparam int unsigned TW = NTAGB + 1;
`else
  localparam int unsigned TW = NTAGB;
`endif

  logic [NLEVELS:0]            lvl_valid;
  logic [NLEVELS:0]            lvl_ready;
  logic [NLEVELS:0][TW-1:0]    lvl_tag;
  logic [NELEMS*F_NBITS-1:0]   lvl_data;
  logic [NGATES-1:0][F_NBITS-1:0] masked_c;
  fe_t                         tree_sum;

  always_comb begin
    for (int i = 0; i < int'(NGATES); i++) masked_c[i] = in_mask[i] ? in[i] : '0;
  end

  assign lvl_valid[0]                = in_valid;
  assign lvl_data[NGATES*F_NBITS-1:0] = masked_c;
  assign in_ready                    = lvl_ready[0];
`ifdef PROVER_ADDER_TREE_ACC_EN
  assign lvl_tag[0] = {in_last, in_tag};
`else
  assign lvl_tag[0] = in_tag;
`endif

  for (genvar k = 0; k < int'(NLEVELS); k++) begin : g_lvl
    localparam int unsigned NIN     = lvl_num_inputs(NGATES, k);
    localparam int unsigned NOUT    = lvl_num_inputs(NGATES, k + 1);
    localparam int unsigned OFF_IN  = lvl_offset(NGATES, k);
    localparam int unsigned OFF_OUT = lvl_offset(NGATES, k + 1);

    prover_tree_stage_vr #(
      .NIN   (NIN),
      .NTAGB (TW)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (lvl_valid[k]),
      .up_ready_c (lvl_ready[k]),
      .up_data    (lvl_data[OFF_IN*F_NBITS +: NIN*F_NBITS]),
      .up_tag     (lvl_tag[k]),
      .dn_valid   (lvl_valid[k+1]),
      .dn_ready   (lvl_ready[k+1]),
      .dn_data    (lvl_data[OFF_OUT*F_NBITS +: NOUT*F_NBITS]),
      .dn_tag     (lvl_tag[k+1])
    );
  end

  assign tree_sum = lvl_data[(NELEMS-1)*F_NBITS +: F_NBITS];

`ifdef PROVER_ADDER_TREE_ACC_EN
  logic             res_valid_q;
  fe_t              acc_q;
  logic [NTAGB-1:0] res_tag_q;
  fe_t              acc_base_c;
  fe_t              acc_sum_c;
  logic             take_c;
  logic             tree_last_c;

  // A held result is being taken whenever the tree can hand over a beat,
  // so a beat arriving alongside it starts a fresh sum from zero.
  assign acc_base_c           = res_valid_q ? '0 : acc_q;
  assign acc_sum_c            = mod_add(acc_base_c, tree_sum);
  assign lvl_ready[NLEVELS]   = ~res_valid_q | out_ready;
  assign take_c               = lvl_valid[NLEVELS] & lvl_ready[NLEVELS];
  assign tree_last_c          = lvl_tag[NLEVELS][NTAGB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      acc_q       <= '0;
      res_tag_q   <= '0;
    end else begin
      if (res_valid_q && out_ready) begin
        res_valid_q <= 1'b0;
        acc_q       <= '0;
      end
      if (take_c) begin
        acc_q <= acc_sum_c;
        if (tree_last_c) begin
          res_valid_q <= 1'b1;
          res_tag_q   <= lvl_tag[NLEVELS][NTAGB-1:0];
        end
      end
    end
  end

  assign out_valid = res_valid_q;
  assign out       = acc_q;
  assign out_tag   = res_tag_q;
  assign idle      = ~(|lvl_valid[NLEVELS:1]) & ~res_valid_q;
`else
  assign lvl_ready[NLEVELS] = out_ready;
  assign out_valid          = lvl_valid[NLEVELS];
  assign out                = tree_sum;
  assign out_tag            = lvl_tag[NLEVELS];
  assign idle               = ~(|lvl_valid[NLEVELS:1]);
`endif

endmodule

// File: tb/tb_prover_adder_tree_vr.sv
// Directed self-checking bench for prover_adder_tree_vr (NGATES=8 and NGATES=5).
`timescale 1ns/1ps
module tb_prover_adder_tree_vr;
  import prover_tree_pkg::*;

  localparam int unsigned FN = F_NBITS;
`ifdef PROVER_ADDER_TREE_ACC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 v8, r8, ov8, ordy8, idle8;
  logic [7:0][FN-1:0]   d8;
  logic [7:0]           m8, t8, ot8;
  fe_t                  o8;
  logic                 v5, r5, ov5, ordy5, idle5;
  logic [4:0][FN-1:0]   d5;
  logic [4:0]           m5;
  logic [7:0]           t5, ot5;
  fe_t                  o5;
`ifdef PROVER_ADDER_TREE_ACC_EN
  logic                 last8, last5;
`endif

  int n_err = 0;
  int n_chk = 0;

  prover_adder_tree_vr #(.NGATES(8), .NTAGB(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in(d8), .in_mask(m8),
    .in_tag(t8),
`ifdef PROVER_ADDER_TREE_ACC_EN
    .in_last(last8),
`endif
    .out_valid(ov8), .out_ready(ordy8), .out(o8), .out_tag(ot8), .idle(idle8)
  );

  prover_adder_tree_vr #(.NGATES(5), .NTAGB(8)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5), .in(d5), .in_mask(m5),
    .in_tag(t5),
`ifdef PROVER_ADDER_TREE_ACC_EN
    .in_last(last5),
`endif
    .out_valid(ov5), .out_ready(ordy5), .out(o5), .out_tag(ot5), .idle(idle5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one beat to dut8, then check latency, sum and tag of its output.
  task automatic run8(input string name, input logic [7:0][FN-1:0] d, input logic [7:0] m,
                      input logic [7:0] tag, input fe_t exp);
    int lat;
    d8 = d; m8 = m; t8 = tag; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(LAT));
    check({name, "_out"}, 64'(o8), 64'(exp));
    check({name, "_tag"}, 64'(ot8), 64'(tag));
    tick();
  endtask

  initial begin
    logic [7:0][FN-1:0] d;
    int lat, idx, nout;
    logic fire;

    rst = 1'b1;
    v8 = 1'b0; d8 = '0; m8 = '1; t8 = '0; ordy8 = 1'b1;
    v5 = 1'b0; d5 = '0; m5 = '1; t5 = '0; ordy5 = 1'b1;
`ifdef PROVER_ADDER_TREE_ACC_EN
    last8 = 1'b1; last5 = 1'b1;
`endif
    #1;
    check("rst_out_valid", 64'(ov8), 64'(0));
    check("rst_out", 64'(o8), 64'(0));
    check("rst_out_tag", 64'(ot8), 64'(0));
    check("rst_idle", 64'(idle8), 64'(1));
    check("rst_in_ready", 64'(r8), 64'(1));
    tick();
    tick();
    rst = 1'b0;

    // Basic sum 1..8
    for (int i = 0; i < 8; i++) d[i] = fe_t'(i + 1);
    run8("sum36", d, 8'hFF, 8'h5A, fe_t'(36));

    // Modular wrap-around
    d = '0; d[0] = F_Q - fe_t'(1); d[1] = fe_t'(2);
    run8("wrap1", d, 8'hFF, 8'h01, fe_t'(1));
    for (int i = 0; i < 8; i++) d[i] = F_Q - fe_t'(1);
    run8("wrap_all", d, 8'hFF, 8'h02, F_Q - fe_t'(8));

    // NGATES=5: back-to-back beats, second one masked
    for (int i = 0; i < 5; i++) d5[i] = fe_t'(i + 1);
    m5 = 5'b11111; t5 = 8'h01; v5 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) d5[i] = fe_t'(10 * (i + 1));
    m5 = 5'b10101; t5 = 8'h02;
    tick();
    v5 = 1'b0;
    lat = 2;
    while (!ov5 && lat < 20) begin
      tick();
      lat++;
    end
    check("g5_lat", 64'(lat), 64'(LAT));
    check("g5_out_a", 64'(o5), 64'(15));
    check("g5_tag_a", 64'(ot5), 64'(8'h01));
    tick();
    check("g5_valid_b", 64'(ov5), 64'(1));
    check("g5_out_b", 64'(o5), 64'(90));
    check("g5_tag_b", 64'(ot5), 64'(8'h02));
    tick();
    check("g5_idle", 64'(idle5), 64'(1));

    // Backpressure: 10 beats, out_ready low for the first 10 cycles
    idx = 0; nout = 0; m8 = 8'hFF;
    for (int c = 0; c < 60 && nout < 10; c++) begin
      ordy8 = (c >= 10);
      v8 = (idx < 10);
      t8 = 8'(idx);
      for (int i = 0; i < 8; i++) d8[i] = fe_t'(idx + i + 1);
      #1;
      if (c == 5 || c == 9) begin
        check("stall_hold_valid", 64'(ov8), 64'(1));
        check("stall_hold_out", 64'(o8), 64'(36));
        check("stall_hold_tag", 64'(ot8), 64'(0));
      end
      if (c == 9) begin
        check("stall_accepts", 64'(idx), 64'(LAT));
        check("stall_in_ready", 64'(r8), 64'(0));
      end
      if (ov8 && ordy8) begin
        check("stream_out", 64'(o8), 64'(8 * nout + 36));
        check("stream_tag", 64'(ot8), 64'(nout));
        nout++;
      end
      fire = v8 && r8;
      tick();
      if (fire) idx++;
    end
    v8 = 1'b0; ordy8 = 1'b1;
    check("stream_count", 64'(nout), 64'(10));
    tick();
    tick();

    // Reset with three beats in flight
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) d8[i] = fe_t'(100 + b);
      t8 = 8'(8'hA0 + b); v8 = 1'b1;
      tick();
    end
    v8 = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(ov8), 64'(0));
    check("mid_rst_idle", 64'(idle8), 64'(1));
    check("mid_rst_out", 64'(o8), 64'(0));
    check("mid_rst_in_ready", 64'(r8), 64'(1));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = fe_t'(i + 1);
    run8("post_rst", d, 8'hFF, 8'h77, fe_t'(36));

`ifdef PROVER_ADDER_TREE_ACC_EN
    // Accumulate three all-ones beats, then a second burst from zero
    for (int i = 0; i < 8; i++) d8[i] = fe_t'(1);
    m8 = 8'hFF; v8 = 1'b1; last8 = 1'b0; t8 = 8'h11;
    tick();
    tick();
    last8 = 1'b1; t8 = 8'h33;
    tick();
    v8 = 1'b0; last8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 20) begin
      tick();
      lat++;
    end
    check("acc_lat", 64'(lat), 64'(4));
    check("acc_out", 64'(o8), 64'(24));
    check("acc_tag", 64'(ot8), 64'(8'h33));
    tick();
    check("acc_single", 64'(ov8), 64'(0));
    for (int i = 0; i < 8; i++) d8[i] = fe_t'(i + 1);
    v8 = 1'b1; last8 = 1'b0; t8 = 8'h44;
    tick();
    last8 = 1'b1; t8 = 8'h55;
    tick();
    v8 = 1'b0; last8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 20) begin
      tick();
      lat++;
    end
    check("acc2_lat", 64'(lat), 64'(4));
    check("acc2_out", 64'(o8), 64'(72));
    check("acc2_tag", 64'(ot8), 64'(8'h55));
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
